// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizes for the UART transmit scheduler and its arbiter.
// Round-robin tie-breaking is enabled by defining UART_TX_SCHED_RR_EN.
package uart_ctrl_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 2;
  localparam int GAP_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-way requester arbiter for the transmit scheduler.
// UART_TX_SCHED_RR_EN selects round-robin ties; otherwise requester 0 always wins ties.
module tx_rr_arbiter
  import uart_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic               grant_valid_o,
  output logic               grant_id_o
);

  // prio_q names the requester that wins when both are pending
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i[0] && req_i[1]) begin
      grant_id_o = prio_q;
    end else begin
      grant_id_o = req_i[1];
    end
  end

  always_comb begin
`ifdef UART_TX_SCHED_RR_EN
    prio_d = accept_i ? ~grant_id_o : prio_q;
`else
    prio_d = accept_i ? 1'b0 : prio_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules 1..4 byte words from two requesters onto a single byte transmitter, LSB first.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration instead of fixed priority.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int IFG_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_len,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy,
  output logic        sched_busy,
  output logic        grant_id
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         sdata_q, sdata_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               grant_q, grant_d;

  logic arbValid;
  logic arbId;
  logic accept;

  assign accept = (state_q == IDLE) && !tx_busy && arbValid;

  tx_rr_arbiter u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        ({req1_valid, req0_valid}),
    .accept_i     (accept),
    .grant_valid_o(arbValid),
    .grant_id_o   (arbId)
  );

  // Outputs are derived from the next state so they line up with the registered state
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    ready_d = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          word_d  = arbId ? req1_data : req0_data;
          cnt_d   = arbId ? req1_len : req0_len;
          grant_d = arbId;
          ready_d = arbId ? 2'b10 : 2'b01;
        end
      end
      SEND: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (cnt_q != '0) begin
            word_d = word_q >> 8;
            cnt_d  = cnt_q - 1'b1;
            if (IFG_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else begin
              state_d = SEND;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SEND;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_start_d = (state_d == SEND);
    sdata_d    = (state_d == SEND) ? word_d[7:0] : sdata_q;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      sdata_q    <= '0;
      ready_q    <= '0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign tx_start   = tx_start_q;
  assign sdata      = sdata_q;
  assign sched_busy = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: IFG_CYCLES, default 0, idle clocks inserted between consecutive bytes of one word (0..255).
REQ-002 Port: clk  in  1  system clock, all state on rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  in  1 each  requester has a word pending.
REQ-005 Port: req0_data / req1_data  in  32 each  word to transmit.
REQ-006 Port: req0_len / req1_len  in  2 each  byte count minus 1 (0 = 1 byte, 3 = 4 bytes).
REQ-007 Port: req0_ready / req1_ready  out  1 each  one-cycle accept pulse; word captured that cycle.
REQ-008 Port: tx_start  out  1  one-cycle start pulse to the byte transmitter.
REQ-009 Port: sdata  out  8  byte to transmit, valid while tx_start is high.
REQ-010 Port: tx_busy  in  1  byte transmitter busy, rises the cycle after tx_start, falls after the stop bit.
REQ-011 Port: sched_busy  out  1  high from accept until the last byte's tx_busy falls.
REQ-012 Port: grant_id  out  1  requester currently being served; holds its last value when idle.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
REQ-014 IDLE: SHALL arbitrate only when tx_busy=0 and at least one valid is high; the winner's ready pulses 1 cycle, data/len latch, grant_id updates, next state is SEND.
REQ-015 IDLE with tx_busy=1: no accept, no tx_start.
REQ-016 SEND: tx_start=1 for exactly one cycle; sdata = latched word bits [7:0]; next state is WAIT_BUSY.
REQ-017 WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE; tx_start stays 0.
REQ-018 WAIT_DONE: on tx_busy=0, if bytes remain, shift the word right by 8 and decrement the count; go to GAP if IFG_CYCLES>0, otherwise to SEND; if none remain, go to IDLE.
REQ-019 GAP: count IFG_CYCLES clocks, then go to SEND.
REQ-020 Byte order SHALL be LSB first; a word of len L produces exactly L+1 tx_start pulses.
REQ-021 tx_start, sdata, ready, sched_busy and grant_id SHALL be registered outputs.
REQ-022 The block SHALL sample valid only in IDLE; a valid that drops before its ready pulse SHALL be ignored; data/len changes after accept SHALL have no effect.
REQ-023 A new accept SHALL occur no earlier than the cycle after WAIT_DONE returns to IDLE.

Reset
REQ-024 Reset SHALL asynchronously force IDLE, tx_start=0, sdata=0, ready=0, sched_busy=0, grant_id=0, the internal byte count and gap counter to 0, and the priority pointer to requester 0.
REQ-025 Reset mid-word SHALL drop the remaining bytes; after release no tx_start occurs until a new accept.

Configuration
REQ-026 Macro UART_TX_SCHED_RR_EN defined: round-robin arbitration; on simultaneous valids, the requester not granted last wins.
REQ-027 Macro undefined: fixed priority, requester 0 always wins ties.

Structure
REQ-028 Package uart_ctrl_pkg SHALL hold the FSM state enum, the requester count (2) and the byte-count width.
REQ-029 The arbitration SHALL be a sub-module tx_rr_arbiter (2-way, with the macro-selected policy), instantiated once.

Verification
REQ-030 req0_valid, len=3, data=0x44332211 -> one req0_ready pulse, sdata 0x11,0x22,0x33,0x44 on 4 tx_start pulses, sched_busy falls after the 4th tx_busy fall.
REQ-031 Both valids held for 4 words -> with RR_EN grant_id 0,1,0,1; without it 0,0,0,0.
REQ-032 IFG_CYCLES=5, len=1 -> at least 5 clocks between the 1st tx_busy fall and the 2nd tx_start.
REQ-033 tx_busy forced high in IDLE with req1_valid -> no ready or tx_start until tx_busy drops, then accept the next cycle.
REQ-034 reset_n asserted after the 2nd byte of a 4-byte word -> outputs at reset values immediately, no further tx_start, next word starts from its byte 0.
